// File: rtl/pll_pkg.sv
// pll_pkg: definitions shared by the PFD loop filter and its synchronizer.
//   - state_t     : loop filter state encoding (IDLE, MEAS_UP, MEAS_DN, UPDATE)
//   - ERR_W_DEF   : default signed phase error width
//   - CTRL_W_DEF  : default signed control word / integrator width
//   - sat_add()   : signed add that clamps the sum to a w-bit signed range
package pll_pkg;

  localparam int ERR_W_DEF  = 8;
  localparam int CTRL_W_DEF = 16;

  typedef enum logic [1:0] {
    IDLE,
    MEAS_UP,
    MEAS_DN,
    UPDATE
  } state_t;

  // Operands are 64 bits wide, so the raw sum can never wrap for any
  // practical w. The result is clamped to [-2^(w-1), 2^(w-1)-1]. Callers
  // take the low w bits.
  function automatic logic signed [63:0] sat_add(input logic signed [63:0] a,
                                                 input logic signed [63:0] b,
                                                 input int                 w);
    logic signed [63:0] sum;
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    sum = a + b;
    hi  = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo  = -(64'sd1 <<< (w - 1));
    if (sum > hi) begin
      return hi;
    end else if (sum < lo) begin
      return lo;
    end
    return sum;
  endfunction

endpackage

// File: rtl/pll_sync2.sv
// pll_sync2: two-flop synchronizer for a single asynchronous level.
// Ports:
//   clk - destination clock
//   rst - asynchronous active-high reset, clears both flops
//   d   - asynchronous input
//   q   - synchronized output, two clk cycles behind d
module pll_sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/pfd_loop_filter.sv
// pfd_loop_filter: digital PI loop filter fed directly by a phase-frequency
// detector. The up and dn pulses are synchronized. Each pulse width is
// measured in clk cycles to form a signed phase error. One PI update is
// issued per detector comparison.
// Ports:
//   clk        - system clock
//   rst        - asynchronous active-high reset
//   en         - filter enable. When low, a measurement is aborted and the
//                filter state holds.
//   up, dn     - PFD pulses, asynchronous to clk
//   ctrl_word  - registered signed control word (CTRL_W bits)
//   ctrl_valid - one-cycle strobe, high in the cycle ctrl_word is updated
//   err        - registered signed error of the latest update (ERR_W bits)
//   locked     - lock indicator
// Optional feature: define PFD_LOOP_FILTER_LOCK_DET_EN to build the lock
// detector. Without it, locked is tied to 0.
module pfd_loop_filter
  import pll_pkg::*;
#(
  parameter int ERR_W     = ERR_W_DEF,
  parameter int CTRL_W    = CTRL_W_DEF,
  parameter int KP_SHIFT  = 2,
  parameter int KI_SHIFT  = 0,
  parameter int CTRL_INIT = 0,
  parameter int LOCK_TOL  = 1,
  parameter int LOCK_CNT  = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic                     up,
  input  logic                     dn,
  output logic signed [CTRL_W-1:0] ctrl_word,
  output logic                     ctrl_valid,
  output logic signed [ERR_W-1:0]  err,
  output logic                     locked
);

  // The count magnitude is at most 2^(ERR_W-1)-1, so one bit less than
  // ERR_W holds it. All-ones in this width is exactly the saturation point.
  localparam int CW = ERR_W - 1;
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [CW-1:0] CNT_MAX = '1;

  logic up_s;
  logic dn_s;

  state_t                    state;
  logic [CW-1:0]             count;
  logic signed [ERR_W-1:0]   e_pend;
  logic signed [CTRL_W-1:0]  integ;
  logic signed [CTRL_W-1:0]  integ_n;
  logic signed [CTRL_W-1:0]  ctrl_n;
  logic signed [63:0]        e_wide;

  pll_sync2 u_sync_up (.clk(clk), .rst(rst), .d(up), .q(up_s));
  pll_sync2 u_sync_dn (.clk(clk), .rst(rst), .d(dn), .q(dn_s));

  // The PI arithmetic is done at 64 bits, so nothing wraps before the clamp.
  // The proportional term is added to the already-updated integrator.
  always_comb begin
    e_wide  = 64'(e_pend);
    integ_n = CTRL_W'(sat_add(64'(integ), e_wide <<< KI_SHIFT, CTRL_W));
    ctrl_n  = CTRL_W'(sat_add(64'(integ_n), e_wide <<< KP_SHIFT, CTRL_W));
  end

  // Measurement / update state machine with registered outputs. A pulse
  // seen on the same edge that leaves UPDATE is picked up from IDLE on the
  // following cycle. Because it is still high there, pulses are never merged.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      count      <= '0;
      e_pend     <= '0;
      integ      <= CTRL_W'(CTRL_INIT);
      ctrl_word  <= CTRL_W'(CTRL_INIT);
      err        <= '0;
      ctrl_valid <= 1'b0;
    end else begin
      ctrl_valid <= 1'b0;
      if (!en) begin
        state <= IDLE;
        count <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (up_s && !dn_s) begin
              state <= MEAS_UP;
              count <= CNT_ONE;
            end else if (dn_s && !up_s) begin
              state <= MEAS_DN;
              count <= CNT_ONE;
            end else if (up_s && dn_s) begin
              state  <= UPDATE;
              e_pend <= '0;
            end
          end
          MEAS_UP: begin
            if (up_s) begin
              if (count != CNT_MAX) count <= count + CNT_ONE;
            end else begin
              state  <= UPDATE;
              e_pend <= $signed({1'b0, count});
              count  <= '0;
            end
          end
          MEAS_DN: begin
            if (dn_s) begin
              if (count != CNT_MAX) count <= count + CNT_ONE;
            end else begin
              state  <= UPDATE;
              e_pend <= -$signed({1'b0, count});
              count  <= '0;
            end
          end
          UPDATE: begin
            integ      <= integ_n;
            ctrl_word  <= ctrl_n;
            err        <= e_pend;
            ctrl_valid <= 1'b1;
            state      <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

`ifdef PFD_LOOP_FILTER_LOCK_DET_EN
  localparam int LW = $clog2(LOCK_CNT + 1);
  localparam logic [LW-1:0] LOCK_MAX = LW'(LOCK_CNT);
  localparam logic [LW-1:0] LOCK_ONE = LW'(1);

  logic [LW-1:0] lock_cnt;
  logic          in_tol;

  assign in_tol = (32'(e_pend) <= LOCK_TOL) && (32'(e_pend) >= -LOCK_TOL);

  // locked changes on the same edge that raises ctrl_valid for the update.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lock_cnt <= '0;
      locked   <= 1'b0;
    end else if (!en) begin
      lock_cnt <= '0;
      locked   <= 1'b0;
    end else if (state == UPDATE) begin
      if (!in_tol) begin
        lock_cnt <= '0;
        locked   <= 1'b0;
      end else if (lock_cnt == LOCK_MAX) begin
        locked <= 1'b1;
      end else begin
        lock_cnt <= lock_cnt + LOCK_ONE;
        locked   <= ((lock_cnt + LOCK_ONE) == LOCK_MAX);
      end
    end
  end
`else
  logic unused_lock_params;
  assign unused_lock_params = ^{32'(LOCK_TOL), 32'(LOCK_CNT)};
  assign locked = 1'b0;
`endif

endmodule

// File: tb/tb_pfd_loop_filter.sv
// tb_pfd_loop_filter: directed, self-checking bench for pfd_loop_filter.
// u_dut0 uses the default parameters. u_dut1 uses an 8-bit control word to
// exercise clamping. Each pulse pushes the modelled result onto that
// instance's queue. The entry is popped and compared when ctrl_valid
// appears.
module tb_pfd_loop_filter;

  localparam int KP = 2;
  localparam int KI = 0;

  logic clk = 1'b0;
  logic rst;
  logic en;
  logic up0, dn0, up1, dn1;

  logic signed [15:0] ctrl0;
  logic signed [7:0]  ctrl1;
  logic signed [7:0]  err0, err1;
  logic               valid0, valid1, lk0, lk1;

  always #5 clk = ~clk;

  pfd_loop_filter u_dut0 (
    .clk(clk), .rst(rst), .en(en), .up(up0), .dn(dn0),
    .ctrl_word(ctrl0), .ctrl_valid(valid0), .err(err0), .locked(lk0)
  );

  pfd_loop_filter #(.ERR_W(8), .CTRL_W(8)) u_dut1 (
    .clk(clk), .rst(rst), .en(en), .up(up1), .dn(dn1),
    .ctrl_word(ctrl1), .ctrl_valid(valid1), .err(err1), .locked(lk1)
  );

  typedef struct {
    int err;
    int ctrl;
    bit locked;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  int   integ_m [2];
  int   ctrl_m  [2];
  int   lock_m  [2];
  int   checks = 0;
  int   errors = 0;

  function automatic int clamp(input int v, input int w);
    int hi;
    int lo;
    hi = (1 <<< (w - 1)) - 1;
    lo = -(1 <<< (w - 1));
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

  task automatic chk(input string tag, input logic signed [31:0] obs,
                     input logic signed [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic modelReset();
    for (int s = 0; s < 2; s++) begin
      integ_m[s] = 0;
      ctrl_m[s]  = 0;
      lock_m[s]  = 0;
    end
  endtask

  task automatic pushExpect(input int sel, input int e);
    exp_t x;
    int   w;
    w = (sel == 1) ? 8 : 16;
    integ_m[sel] = clamp(integ_m[sel] + e * (1 <<< KI), w);
    ctrl_m[sel]  = clamp(integ_m[sel] + e * (1 <<< KP), w);
    if (e >= -1 && e <= 1) lock_m[sel] = (lock_m[sel] < 8) ? lock_m[sel] + 1 : 8;
    else lock_m[sel] = 0;
    x.err  = e;
    x.ctrl = ctrl_m[sel];
`ifdef PFD_LOOP_FILTER_LOCK_DET_EN
    x.locked = (lock_m[sel] == 8);
`else
    x.locked = 1'b0;
`endif
    if (sel == 1) q1.push_back(x);
    else q0.push_back(x);
  endtask

  task automatic setPins(input int sel, input logic u, input logic d);
    if (sel == 1) begin
      up1 = u;
      dn1 = d;
    end else begin
      up0 = u;
      dn0 = d;
    end
  endtask

  // Drives up for up_w clk cycles and/or dn for dn_w cycles, both starting
  // together. Returns on the negedge where the last pulse has dropped.
  task automatic applyStimulus(input int sel, input int up_w, input int dn_w);
    int  e;
    int  maxw;
    logic u;
    logic d;
    if (up_w > 0 && dn_w > 0) e = 0;
    else if (up_w > 0) e = (up_w > 127) ? 127 : up_w;
    else e = (dn_w > 127) ? -127 : -dn_w;
    pushExpect(sel, e);
    maxw = (up_w > dn_w) ? up_w : dn_w;
    u = (up_w > 0);
    d = (dn_w > 0);
    @(negedge clk);
    setPins(sel, u, d);
    for (int i = 1; i <= maxw; i++) begin
      @(negedge clk);
      if (i == up_w) u = 1'b0;
      if (i == dn_w) d = 1'b0;
      setPins(sel, u, d);
    end
  endtask

  // Waits (bounded) for ctrl_valid and compares it against the queue head.
  // exp_lat > 0 also checks how many posedges after the drop it appeared.
  task automatic checkOutput(input int sel, input string tag, input int exp_lat);
    bit   got;
    int   lat;
    exp_t x;
    got = 1'b0;
    lat = 0;
    for (int k = 1; k <= 30 && !got; k++) begin
      @(posedge clk);
      #1;
      if ((sel == 1) ? valid1 : valid0) begin
        got = 1'b1;
        lat = k;
      end
    end
    chk({tag, "_valid_seen"}, 32'(got), 1);
    if (!got) begin
      if (sel == 1 && q1.size() > 0) void'(q1.pop_front());
      if (sel == 0 && q0.size() > 0) void'(q0.pop_front());
      return;
    end
    chk({tag, "_queue_nonempty"}, (sel == 1) ? q1.size() : q0.size(), 1);
    if (sel == 1) x = q1.pop_front();
    else x = q0.pop_front();
    if (exp_lat > 0) chk({tag, "_latency"}, lat, exp_lat);
    chk({tag, "_err"}, (sel == 1) ? 32'(err1) : 32'(err0), x.err);
    chk({tag, "_ctrl"}, (sel == 1) ? 32'(ctrl1) : 32'(ctrl0), x.ctrl);
    chk({tag, "_locked"}, 32'((sel == 1) ? lk1 : lk0), 32'(x.locked));
    @(posedge clk);
    #1;
    chk({tag, "_strobe_one_cycle"}, 32'((sel == 1) ? valid1 : valid0), 0);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int seen;
    rst = 1'b1;
    en  = 1'b1;
    up0 = 1'b0; dn0 = 1'b0; up1 = 1'b0; dn1 = 1'b0;
    modelReset();
    #2;
    chk("init_ctrl0", 32'(ctrl0), 0);
    chk("init_valid0", 32'(valid0), 0);
    chk("init_err0", 32'(err0), 0);
    chk("init_locked0", 32'(lk0), 0);
    chk("init_ctrl1", 32'(ctrl1), 0);
    chk("init_err1", 32'(err1), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Simultaneous one-cycle up and dn from a fresh integrator
    applyStimulus(0, 1, 1);
    checkOutput(0, "same_edge", 0);

    // Up pulse of 5 clks, then a 3-clk dn pulse
    applyStimulus(0, 5, 0);
    checkOutput(0, "up5", 4);
    applyStimulus(0, 0, 3);
    checkOutput(0, "dn3", 4);

    // Drop en in the middle of a 10-clk up pulse
    seen = 0;
    @(negedge clk);
    up0 = 1'b1;
    for (int i = 1; i <= 18; i++) begin
      @(negedge clk);
      if (valid0) seen = 1;
      if (i == 3) en = 1'b0;
      if (i == 10) up0 = 1'b0;
    end
    en = 1'b1;
    repeat (4) begin
      @(negedge clk);
      if (valid0) seen = 1;
    end
    chk("en_drop_no_valid", seen, 0);
    chk("en_drop_ctrl_hold", 32'(ctrl0), -10);
    chk("en_drop_err_hold", 32'(err0), -3);

    // 8-bit control word: count saturation and clamping at both rails
    applyStimulus(1, 200, 0);
    checkOutput(1, "sat_up200", 4);
    applyStimulus(1, 50, 0);
    checkOutput(1, "sat_up50a", 4);
    applyStimulus(1, 50, 0);
    checkOutput(1, "sat_up50b", 4);
    applyStimulus(1, 0, 200);
    checkOutput(1, "sat_dn200", 4);

    // Reset asserted part-way through a measurement
    @(negedge clk);
    up0 = 1'b1;
    repeat (4) @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("midrst_ctrl0", 32'(ctrl0), 0);
    chk("midrst_valid0", 32'(valid0), 0);
    chk("midrst_err0", 32'(err0), 0);
    chk("midrst_locked0", 32'(lk0), 0);
    chk("midrst_ctrl1", 32'(ctrl1), 0);
    modelReset();
    @(negedge clk);
    up0 = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    seen = 0;
    repeat (8) begin
      @(negedge clk);
      if (valid0) seen = 1;
    end
    chk("midrst_no_partial_update", seen, 0);

    // Eight small-error updates, then a large one
    for (int n = 0; n < 8; n++) begin
      if (n % 2 == 0) applyStimulus(0, 1, 0);
      else applyStimulus(0, 0, 1);
      checkOutput(0, $sformatf("lock_step%0d", n), 4);
    end
    applyStimulus(0, 4, 0);
    checkOutput(0, "lock_break", 4);

    chk("q0_drained", q0.size(), 0);
    chk("q1_drained", q1.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
